// File: rtl/opfetch_pkg.sv
// Shared types and constants for the register-bank read initiator (regread_initiator).
// Holds the FSM state enum, slot indices, bus widths and slot selection helpers.
package opfetch_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_SLOTS = 3;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT,
        OUT
    } state_e;

    // Lowest enabled slot wins, giving the fixed A, B, C read order.
    function automatic logic [1:0] lowest_slot(input logic [NUM_SLOTS-1:0] mask);
        if (mask[0]) begin
            return SLOT_A;
        end else if (mask[1]) begin
            return SLOT_B;
        end else begin
            return SLOT_C;
        end
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [NUM_SLOTS*ADDR_W-1:0] addrs,
                                                    input logic [1:0] slot);
        case (slot)
            SLOT_A:  return addrs[3:0];
            SLOT_B:  return addrs[7:4];
            default: return addrs[11:8];
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the bank's asynchronous ready level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic stage1_q;
    logic stage2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/regread_initiator.sv
// Fetches up to three operands from the register bank through its toggle-triggered read port.
// Optional WAIT timeout with sticky errOut is enabled by defining OPFETCH_TIMEOUT_EN.
module regread_initiator
    import opfetch_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 3,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          reqValid,
    output logic                          reqReady,
    input  logic [NUM_SLOTS-1:0]          reqMask,
    input  logic [NUM_SLOTS*ADDR_W-1:0]   reqAddr,
    output logic                          opValid,
    input  logic                          opReady,
    output logic [DATA_W-1:0]             opA,
    output logic [DATA_W-1:0]             opB,
    output logic [DATA_W-1:0]             opC,
    output logic                          rbTrigger,
    output logic [ADDR_W-1:0]             rbAddr,
    input  logic                          rbReady,
    input  logic [DATA_W-1:0]             rbData,
    output logic                          busy,
    output logic                          errOut
);

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);

    state_e                              state_q, state_d;
    logic [NUM_SLOTS-1:0]                mask_q, mask_d;
    logic [NUM_SLOTS*ADDR_W-1:0]         addr_q, addr_d;
    logic [1:0]                          slot_q, slot_d;
    logic [ADDR_W-1:0]                   rb_addr_q, rb_addr_d;
    logic                                rb_trig_q, rb_trig_d;
    logic [3:0]                          settle_q, settle_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0]    op_q, op_d;
    logic                                rdy_sync;

    logic                                cap_en;
    logic [DATA_W-1:0]                   cap_word;
    logic [NUM_SLOTS-1:0]                rem_mask;
    logic [1:0]                          next_slot;

`ifdef OPFETCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    sync2 u_rdy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rbReady),
        .q     (rdy_sync)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        slot_d    = slot_q;
        rb_addr_d = rb_addr_q;
        rb_trig_d = rb_trig_q;
        settle_d  = settle_q;
        op_d      = op_q;
        cap_en    = 1'b0;
        cap_word  = '0;
        rem_mask  = '0;
        next_slot = SLOT_A;
`ifdef OPFETCH_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    mask_d = reqMask;
                    addr_d = reqAddr;
                    op_d   = '0;
                    if (reqMask == '0) begin
                        state_d = OUT;
                    end else begin
                        next_slot = lowest_slot(reqMask);
                        slot_d    = next_slot;
                        rb_addr_d = slot_addr(reqAddr, next_slot);
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                rb_trig_d = ~rb_trig_q;
                settle_d  = '0;
`ifdef OPFETCH_TIMEOUT_EN
                tmo_d     = '0;
`endif
                state_d   = WAIT;
            end
            WAIT: begin
                if (settle_q != '1) begin
                    settle_d = settle_q + 4'd1;
                end
`ifdef OPFETCH_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
`endif
                if (settle_q >= SETTLE_LIM && rdy_sync) begin
                    state_d = CAPT;
`ifdef OPFETCH_TIMEOUT_EN
                end else if (tmo_q == TMO_LIM) begin
                    // Timed-out slot completes here directly, skipping CAPT.
                    cap_en   = 1'b1;
                    cap_word = '0;
                    err_d    = 1'b1;
`endif
                end
            end
            CAPT: begin
                cap_en   = 1'b1;
                cap_word = rbData;
            end
            OUT: begin
                if (opReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap_en) begin
            op_d[slot_q] = cap_word;
            rem_mask     = mask_q & ~(3'b001 << slot_q);
            mask_d       = rem_mask;
            if (rem_mask != '0) begin
                next_slot = lowest_slot(rem_mask);
                slot_d    = next_slot;
                rb_addr_d = slot_addr(addr_q, next_slot);
                state_d   = REQ;
            end else begin
                state_d   = OUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            slot_q    <= SLOT_A;
            rb_addr_q <= '0;
            rb_trig_q <= 1'b0;
            settle_q  <= '0;
            op_q      <= '0;
`ifdef OPFETCH_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            slot_q    <= slot_d;
            rb_addr_q <= rb_addr_d;
            rb_trig_q <= rb_trig_d;
            settle_q  <= settle_d;
            op_q      <= op_d;
`ifdef OPFETCH_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign reqReady  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign opValid   = (state_q == OUT);
    assign opA       = op_q[SLOT_A];
    assign opB       = op_q[SLOT_B];
    assign opC       = op_q[SLOT_C];
    assign rbTrigger = rb_trig_q;
    assign rbAddr    = rb_addr_q;

`ifdef OPFETCH_TIMEOUT_EN
    assign errOut = err_q;
`else
    assign errOut = 1'b0;
`endif

endmodule

// File: tb/tb_regread_initiator.sv
// Directed self-checking bench for regread_initiator with a behavioural toggle-protocol bank.
// The timeout scenario is exercised only when OPFETCH_TIMEOUT_EN is defined.
module tb_regread_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqMask;
    logic [11:0] reqAddr;
    logic        opValid;
    logic        opReady;
    logic [31:0] opA, opB, opC;
    logic        rbTrigger;
    logic [3:0]  rbAddr;
    logic        rbReady;
    logic [31:0] rbData;
    logic        busy;
    logic        errOut;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    int unsigned edges     = 0;
    logic [3:0]  addr_log[$];
    logic        bank_mute = 1'b0;
    logic [31:0] bank[16];

    always #5 clk = ~clk;

    regread_initiator #(.SETTLE_CYC(3), .TIMEOUT_CYC(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqMask   (reqMask),
        .reqAddr   (reqAddr),
        .opValid   (opValid),
        .opReady   (opReady),
        .opA       (opA),
        .opB       (opB),
        .opC       (opC),
        .rbTrigger (rbTrigger),
        .rbAddr    (rbAddr),
        .rbReady   (rbReady),
        .rbData    (rbData),
        .busy      (busy),
        .errOut    (errOut)
    );

    // Bank: ready drops right after a trigger edge and returns one clock later with data.
    always @(rbTrigger) begin
        if (rst_n === 1'b1) begin
            edges++;
            addr_log.push_back(rbAddr);
        end
        #1 rbReady = 1'b0;
        @(posedge clk);
        #1;
        if (!bank_mute) begin
            rbData  = bank[rbAddr];
            rbReady = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [2:0] m, input logic [11:0] a, output int lat);
        check("req_ready_before", {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1;
        reqMask  = m;
        reqAddr  = a;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        lat = 1;
        while (!opValid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("op_valid_reached", {31'b0, opValid}, 32'd1);
    endtask

    task automatic release_out();
        opReady = 1'b1;
        @(posedge clk);
        #1;
        opReady = 1'b0;
        check("out_op_valid_drop", {31'b0, opValid}, 32'd0);
        check("out_back_idle", {31'b0, reqReady}, 32'd1);
    endtask

    initial begin
        int lat;
        int unsigned e0;

        for (int i = 0; i < 16; i++) bank[i] = 32'hA000_0000 + 32'(i);
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        bank[3] = 32'h0000_1234;
        bank[4] = 32'hFFFF_FFFF;

        rst_n    = 1'b0;
        reqValid = 1'b0;
        reqMask  = '0;
        reqAddr  = '0;
        opReady  = 1'b0;
        rbReady  = 1'b1;
        rbData   = '0;

        step(3);
        check("rst_rbTrigger", {31'b0, rbTrigger}, 32'd0);
        check("rst_rbAddr", {28'b0, rbAddr}, 32'd0);
        check("rst_opValid", {31'b0, opValid}, 32'd0);
        check("rst_opA", opA, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_errOut", {31'b0, errOut}, 32'd0);
        rst_n = 1'b1;
        step(2);
        check("post_rst_reqReady", {31'b0, reqReady}, 32'd1);

        // Three reads: A=r1, B=r2, C=r4.
        addr_log.delete();
        e0 = edges;
        run_req(3'b111, 12'h421, lat);
        check("three_latency", 32'(lat), 32'd19);
        check("three_edges", edges - e0, 32'd3);
        check("three_log_size", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) begin
            check("three_addr0", {28'b0, addr_log[0]}, 32'd1);
            check("three_addr1", {28'b0, addr_log[1]}, 32'd2);
            check("three_addr2", {28'b0, addr_log[2]}, 32'd4);
        end
        check("three_opA", opA, 32'd5);
        check("three_opB", opB, 32'd7);
        check("three_opC", opC, 32'hFFFF_FFFF);
        check("trig_parity1", {31'b0, rbTrigger}, {31'b0, edges[0]});

        // Back-pressure on the same bundle.
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_opValid", {31'b0, opValid}, 32'd1);
            check("bp_reqReady", {31'b0, reqReady}, 32'd0);
            check("bp_opB", opB, 32'd7);
        end
        release_out();
        check("bp_busy_after", {31'b0, busy}, 32'd0);

        // Single read of r3; upper address nibbles are ignored.
        addr_log.delete();
        e0 = edges;
        run_req(3'b001, 12'h873, lat);
        check("single_latency", 32'(lat), 32'd7);
        check("single_edges", edges - e0, 32'd1);
        check("single_rbAddr", {28'b0, rbAddr}, 32'd3);
        check("single_opA", opA, 32'h0000_1234);
        check("single_opB", opB, 32'd0);
        check("single_opC", opC, 32'd0);
        release_out();

        // Empty mask: no bank traffic, cleared operands, rbAddr held.
        e0 = edges;
        run_req(3'b000, 12'h123, lat);
        check("empty_latency", 32'(lat), 32'd1);
        check("empty_edges", edges - e0, 32'd0);
        check("empty_opA", opA, 32'd0);
        check("empty_rbAddr_hold", {28'b0, rbAddr}, 32'd3);
        release_out();

        // Repeated address is read twice.
        addr_log.delete();
        e0 = edges;
        run_req(3'b011, 12'h033, lat);
        check("repeat_latency", 32'(lat), 32'd13);
        check("repeat_edges", edges - e0, 32'd2);
        check("repeat_opA", opA, 32'h0000_1234);
        check("repeat_opB", opB, 32'h0000_1234);
        check("repeat_opC", opC, 32'd0);
        release_out();

        // Reset asserted while waiting on the bank.
        reqValid = 1'b1;
        reqMask  = 3'b001;
        reqAddr  = 12'h005;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        step(3);
        check("midwait_busy", {31'b0, busy}, 32'd1);
        check("trig_parity2", {31'b0, rbTrigger}, {31'b0, edges[0]});
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rbTrigger", {31'b0, rbTrigger}, 32'd0);
        check("midrst_rbAddr", {28'b0, rbAddr}, 32'd0);
        check("midrst_opValid", {31'b0, opValid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_opA", opA, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("midrst_reqReady", {31'b0, reqReady}, 32'd1);
        check("midrst_busy_after", {31'b0, busy}, 32'd0);

`ifdef OPFETCH_TIMEOUT_EN
        bank_mute = 1'b1;
        run_req(3'b001, 12'h006, lat);
        check("tmo_opA", opA, 32'd0);
        check("tmo_errOut", {31'b0, errOut}, 32'd1);
        release_out();
        bank_mute = 1'b0;
        rbReady   = 1'b1;
        step(3);
        run_req(3'b010, 12'h020, lat);
        check("tmo_next_opB", opB, 32'd7);
        check("tmo_err_sticky", {31'b0, errOut}, 32'd1);
        release_out();
        rst_n = 1'b0;
        #1;
        check("tmo_err_cleared", {31'b0, errOut}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
`else
        check("no_tmo_errOut", {31'b0, errOut}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regread_initiator.md
Name: regread_initiator

Overview:
- Clocked requester for the register bank's toggle-triggered read port.
- Accepts up to three source-register addresses (Rn, Rm, Rs) from the decoder on a valid/ready handshake.
- Issues one toggle-protocol read per enabled address, synchronizes the bank's ready level and captures each read word.
- Presents the operand bundle to the issue stage on a second valid/ready handshake. Sits between the decoder and the register bank's read side.

Parameters:
- SETTLE_CYC, 3: minimum clock cycles after a trigger toggle before the ready level is trusted (covers the bank's ready low-pulse plus synchronizer delay); legal range 2..15.
- TIMEOUT_CYC, 64: WAIT-state cycle limit; used only with OPFETCH_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqValid  in  1  decoder offers a read request
- reqReady  out  1  block accepts a request this cycle
- reqMask  in  3  bit0=A(Rn), bit1=B(Rm), bit2=C(Rs) enables
- reqAddr  in  12  [3:0]=A, [7:4]=B, [11:8]=C register numbers
- opValid  out  1  operand bundle valid
- opReady  in  1  issue stage accepts the bundle
- opA/opB/opC  out  32 each  captured operands; 0 for disabled slots
- rbTrigger  out  1  read trigger to the bank; every edge is one request
- rbAddr  out  4  read address to the bank
- rbReady  in  1  bank ready level (asynchronous to clk)
- rbData  in  32  bank read data (asynchronous, stable while rbReady=1)
- busy  out  1  high in any state except IDLE
- errOut  out  1  sticky timeout flag; tied 0 without the macro

Behaviour:
- Reset values: rbTrigger=0, rbAddr=0, opValid=0, opA/opB/opC=0, busy=0, errOut=0, state=IDLE, so reqReady=1 once reset is released.
- rbReady passes through a 2-flop synchronizer (rdySync) before use.
- IDLE: reqReady=1.
  - On reqValid&reqReady, latch reqMask and reqAddr, and clear opA/opB/opC.
  - Mask 0 → OUT next cycle.
  - Otherwise select the lowest set mask bit, drive its address on rbAddr, and go to REQ.
- REQ (1 cycle): rbAddr has been stable at least one cycle. Invert rbTrigger on exit, load the settle counter with 0, then go to WAIT.
- WAIT: the counter increments every cycle.
  - When counter >= SETTLE_CYC and rdySync=1, go to CAPT.
  - rdySync=0 extends WAIT indefinitely unless the macro is enabled.
- CAPT (1 cycle): register rbData into the selected slot and clear that mask bit.
  - If bits remain set, select the next lowest bit, update rbAddr and go to REQ.
  - If none remain, go to OUT.
- OUT: opValid=1, with operands held stable, until opReady=1. Then opValid=0 in the following cycle and return to IDLE.
- Requests are accepted only in IDLE, so there is at least one bubble between bundles.
- Latency, from acceptance to opValid: 1 + N*(SETTLE_CYC+3) cycles for N enabled operands when the bank responds promptly. With SETTLE_CYC=3 and N=1 this is 7 cycles.
- Order: A then B then C. A repeated address is read again, not forwarded.
- rbAddr holds its last value in IDLE/OUT. rbTrigger never toggles outside REQ.
- Reset mid-operation: all state is abandoned. rbTrigger returning to 0 may create one spurious bank read. This is harmless because reads have no side effects, and it is documented as allowed.
- opReady high outside OUT is ignored. reqValid during a busy state is not accepted and must be held by the decoder.

Optional Feature:
- OPFETCH_TIMEOUT_EN defined: if WAIT reaches TIMEOUT_CYC cycles, capture 32'h0 into the slot, set errOut (sticky until reset), and continue as if CAPT completed.
- Undefined: no timeout counter logic; errOut constant 0; WAIT waits forever.

Decomposition:
- opfetch_pkg: state enum (IDLE, REQ, WAIT, CAPT, OUT), slot index constants (SLOT_A=0, SLOT_B=1, SLOT_C=2), address/data width constants.
- Sub-module: sync2, a 2-flop synchronizer for rbReady, instantiated once.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT → all outputs at reset values immediately; after release, reqReady=1 and busy=0.
- Single read: bank r3=32'h0000_1234, reqMask=3'b001, reqAddr[3:0]=3 → exactly one rbTrigger edge, rbAddr=3, opA=32'h1234, opB=opC=0, opValid at cycle 7.
- Three reads: r1=5, r2=7, r4=32'hFFFF_FFFF, mask 3'b111 → three trigger edges with rbAddr order 1,2,4; opA=5, opB=7, opC=32'hFFFF_FFFF.
- Empty mask: mask 3'b000 → no trigger edge; opValid on the next cycle with all operands 0.
- Back-pressure: opReady held 0 for 5 cycles in OUT → operands stable, opValid=1 throughout, reqReady=0; IDLE reached one cycle after opReady=1.
- Timeout (macro on, TIMEOUT_CYC=64): rbReady held 0 → opA=0 and errOut=1 after 64 WAIT cycles; errOut stays 1 until reset.
